// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 arrow-key scheduler: scancodes, direction
// indices, scheduler state encoding and small one-hot helpers.
package ps2_key_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } sched_state_e;

  // Fallback arbitration: lowest index wins (up > down > left > right).
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [1:0] dir_of(input logic [3:0] onehot);
    case (onehot)
      4'b0001: return DIR_UP;
      4'b0010: return DIR_DOWN;
      4'b0100: return DIR_LEFT;
      4'b1000: return DIR_RIGHT;
      default: return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/ps2_arrow_decode.sv
// Combinational classifier: maps a decoder frame to an arrow direction,
// flagging whether it is an extended arrow code and whether it is a release.
module ps2_arrow_decode
  import ps2_key_pkg::*;
(
  input  logic [9:0] frame_i,
  output logic       valid_o,
  output logic       is_break_o,
  output logic [1:0] dir_o
);

  // Arrow keys only count when the E0 prefix flag is present.
  always_comb begin
    valid_o    = 1'b0;
    dir_o      = DIR_UP;
    is_break_o = frame_i[9];
    case (frame_i[7:0])
      SC_UP:    begin valid_o = frame_i[8]; dir_o = DIR_UP;    end
      SC_DOWN:  begin valid_o = frame_i[8]; dir_o = DIR_DOWN;  end
      SC_LEFT:  begin valid_o = frame_i[8]; dir_o = DIR_LEFT;  end
      SC_RIGHT: begin valid_o = frame_i[8]; dir_o = DIR_RIGHT; end
      default:  begin valid_o = 1'b0;       dir_o = DIR_UP;    end
    endcase
  end

endmodule

// File: rtl/ps2_arrow_scheduler.sv
// Turns PS/2 arrow make/break frames into move pulses: tracks held keys,
// arbitrates (latest press wins) and generates its own delay/repeat cadence.
module ps2_arrow_scheduler
  import ps2_key_pkg::*;
#(
  parameter int DELAY_CYC  = 30000000,
  parameter int REPEAT_CYC = 10000000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ps2_out,
  input  logic       ps2_ready,
  input  logic       enable,
  output logic [3:0] held,
  output logic [3:0] active,
  output logic       move_pulse,
  output logic [1:0] move_dir
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);

  logic             dec_valid_s;
  logic             dec_break_s;
  logic [1:0]       dec_dir_s;
  logic [3:0]       key_oh_s;
  logic [3:0]       held_q, held_d;
  logic [3:0]       active_q, active_d;
  logic             pulse_q;
  logic [1:0]       dir_q;
  logic [CNT_W-1:0] cnt_q;
  sched_state_e     state_q;

  ps2_arrow_decode u_decode (
    .frame_i    (ps2_out),
    .valid_o    (dec_valid_s),
    .is_break_o (dec_break_s),
    .dir_o      (dec_dir_s)
  );

  assign key_oh_s = 4'b0001 << dec_dir_s;

  // Held/active update from an accepted frame; typematic makes and breaks
  // of keys that are not held fall through unchanged.
  always_comb begin
    held_d   = held_q;
    active_d = active_q;
    if (ps2_ready && dec_valid_s) begin
      if (!dec_break_s && ((held_q & key_oh_s) == 4'd0)) begin
        held_d   = held_q | key_oh_s;
        active_d = key_oh_s;
      end else if (dec_break_s && ((held_q & key_oh_s) != 4'd0)) begin
        held_d = held_q & ~key_oh_s;
        if (active_q == key_oh_s) begin
          active_d = lowest_set(held_q & ~key_oh_s);
        end else begin
          active_d = active_q;
        end
      end else begin
        held_d   = held_q;
        active_d = active_q;
      end
    end else begin
      held_d   = held_q;
      active_d = active_q;
    end
  end

  // Scheduler FSM, cadence counter and registered outputs. A frame-driven
  // direction change is checked before timer expiry so the frame wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 4'd0;
      active_q <= 4'd0;
      pulse_q  <= 1'b0;
      dir_q    <= 2'd0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      held_q   <= held_d;
      active_q <= active_d;
      pulse_q  <= 1'b0;
      if (!enable || (active_d == 4'd0)) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if ((active_d != active_q) || (state_q == ST_IDLE)) begin
        pulse_q <= 1'b1;
        dir_q   <= dir_of(active_d);
        cnt_q   <= '0;
        state_q <= ST_DELAY;
      end else if ((state_q == ST_DELAY) && (cnt_q == DLY_LAST)) begin
        pulse_q <= 1'b1;
        dir_q   <= dir_of(active_q);
        cnt_q   <= '0;
        state_q <= ST_REPEAT;
      end else if ((state_q == ST_REPEAT) && (cnt_q == RPT_LAST)) begin
        pulse_q <= 1'b1;
        dir_q   <= dir_of(active_q);
        cnt_q   <= '0;
        state_q <= ST_REPEAT;
      end else if ((state_q == ST_DELAY) || (state_q == ST_REPEAT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q   <= '0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign held       = held_q;
  assign active     = active_q;
  assign move_pulse = pulse_q;
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_ps2_arrow_scheduler.sv
// Self-checking bench: directed scenarios plus random frames, compared every
// cycle against a timestamp-based reference model of the key scheduler.
module tb_ps2_arrow_scheduler;

  localparam int DLY = 8;
  localparam int RPT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ps2_out = 10'h000;
  logic       ps2_ready = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] held;
  logic [3:0] active;
  logic       move_pulse;
  logic [1:0] move_dir;

  ps2_arrow_scheduler #(.DELAY_CYC(DLY), .REPEAT_CYC(RPT), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_out    (ps2_out),
    .ps2_ready  (ps2_ready),
    .enable     (enable),
    .held       (held),
    .active     (active),
    .move_pulse (move_pulse),
    .move_dir   (move_dir)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int plog[$];

  // Reference model: held set, active key index, and absolute cycle of the
  // next scheduled pulse (-1 when nothing is scheduled).
  bit m_held[4];
  int m_act   = -1;
  int m_next  = -1;
  int m_dir   = 0;
  bit m_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_held();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_held[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int exp_active();
    return (m_act < 0) ? 0 : (1 << m_act);
  endfunction

  function automatic int fallback();
    for (int i = 0; i < 4; i++) if (m_held[i]) return i;
    return -1;
  endfunction

  function automatic int pulses_in(input int lo, input int hi);
    int n = 0;
    foreach (plog[i]) if (plog[i] >= lo && plog[i] <= hi) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
    m_act = -1; m_next = -1; m_dir = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    int prev = m_act;
    int d = -1;
    m_pulse = 1'b0;
    if (ps2_ready && ps2_out[8]) begin
      case (ps2_out[7:0])
        8'h75:   d = 0;
        8'h72:   d = 1;
        8'h6B:   d = 2;
        8'h74:   d = 3;
        default: d = -1;
      endcase
      if (d >= 0) begin
        if (!ps2_out[9] && !m_held[d]) begin
          m_held[d] = 1'b1;
          m_act = d;
        end else if (ps2_out[9] && m_held[d]) begin
          m_held[d] = 1'b0;
          if (m_act == d) m_act = fallback();
        end
      end
    end
    if (!enable || m_act < 0) begin
      m_next = -1;
    end else if (m_act != prev || m_next < 0) begin
      m_pulse = 1'b1; m_dir = m_act; m_next = cyc + DLY;
    end else if (cyc == m_next) begin
      m_pulse = 1'b1; m_next = cyc + RPT;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("held", held, exp_held());
    check("active", active, exp_active());
    check("move_pulse", move_pulse, m_pulse);
    check("move_dir", move_dir, m_dir);
    if (move_pulse) plog.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [9:0] f);
    ps2_out = f;
    ps2_ready = 1'b1;
    tick();
    ps2_ready = 1'b0;
    ps2_out = 10'h000;
  endtask

  initial begin
    int t0;
    int t1;
    logic [7:0] codes [4];
    codes[0] = 8'h75; codes[1] = 8'h72; codes[2] = 8'h6B; codes[3] = 8'h74;
    model_reset();

    #2;
    check("rst_held", held, 0);
    check("rst_active", active, 0);
    check("rst_pulse", move_pulse, 0);
    check("rst_dir", move_dir, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Press and hold up: pulses at +0, +8, +12, +16, then release.
    send(10'h175); t0 = cyc;
    check("up_first_dir", move_dir, 0);
    idle(17);
    check("hold_pulse_count", pulses_in(t0, t0 + 16), 4);
    check("hold_first_repeat", pulses_in(t0 + 8, t0 + 8), 1);
    check("hold_second_repeat", pulses_in(t0 + 12, t0 + 12), 1);
    send(10'h375); t1 = cyc;
    idle(12);
    check("release_no_pulse", pulses_in(t1, cyc), 0);

    // Typematic makes of a held key leave the schedule unchanged.
    send(10'h175); t0 = cyc;
    idle(2); send(10'h175);
    idle(2); send(10'h175);
    idle(11);
    check("typematic_count", pulses_in(t0, t0 + 16), 4);
    check("typematic_repeat", pulses_in(t0 + 8, t0 + 8), 1);
    send(10'h375); idle(3);

    // Arbitration: newest press wins, release falls back to up.
    send(10'h175); idle(3);
    send(10'h16B); t1 = cyc;
    check("arb_left_pulse", move_pulse, 1);
    check("arb_left_dir", move_dir, 2);
    idle(8);
    check("arb_delay_restart", pulses_in(t1 + 8, t1 + 8), 1);
    send(10'h36B);
    check("arb_fallback_active", active, 4'b0001);
    check("arb_fallback_pulse", move_pulse, 1);
    check("arb_fallback_dir", move_dir, 0);
    send(10'h375);
    check("arb_idle_active", active, 0);
    idle(3);

    // Ignored frames: no E0, foreign code, break of an unheld key.
    send(10'h175);
    send(10'h075); check("ign_noext_held", held, 4'b0001); check("ign_noext_pulse", move_pulse, 0);
    send(10'h11C); check("ign_code_held", held, 4'b0001); check("ign_code_pulse", move_pulse, 0);
    send(10'h374); check("ign_brk_active", active, 4'b0001); check("ign_brk_pulse", move_pulse, 0);
    send(10'h375); idle(3);

    // Frame collides with the delay expiry: one pulse, new direction.
    send(10'h16B); t0 = cyc;
    idle(7);
    send(10'h172);
    check("collide_pulse", move_pulse, 1);
    check("collide_dir", move_dir, 1);
    tick();
    check("collide_single", move_pulse, 0);
    enable = 1'b0; t1 = cyc;
    idle(20);
    check("disable_no_pulse", pulses_in(t1 + 1, cyc), 0);
    check("disable_held", held, 4'b0110);
    enable = 1'b1;
    tick();
    check("enable_pulse", move_pulse, 1);
    check("enable_dir", move_dir, 1);

    // Asynchronous reset while repeating.
    idle(14);
    #2 rst_n = 1'b0;
    #1;
    check("async_held", held, 0);
    check("async_active", active, 0);
    check("async_pulse", move_pulse, 0);
    check("async_dir", move_dir, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    send(10'h175);
    check("post_reset_pulse", move_pulse, 1);
    check("post_reset_held", held, 4'b0001);
    send(10'h375); send(10'h36B); send(10'h372); idle(2);

    // Random frames and enable toggles against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ps2_out[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 3)];
        ps2_out[8] = ($urandom_range(0, 7) != 0);
        ps2_out[9] = $urandom_range(0, 1) == 1;
        ps2_ready = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      tick();
      ps2_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
